alu_response_checker: RTL and testbench

Synthesizable response side of the ALU test loop. Accepts one operation descriptor at a time over a valid/ready handshake and drives it onto the `alu` operand/select inputs. After a programmable settle interval it samples the ALU's `S` and `Cout` outputs and compares them against an internally computed golden result. It accumulates pass/fail statistics and latches the first mismatch for on-chip or bench inspection.

---
 rtl/alu_response_checker.sv | 143 ++++++++++++++
 tb/tb_alu_response_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_response_checker.sv
// Response side of the ALU test loop: drives one operation onto the ALU, waits
// SETTLE cycles, compares S/Cout against a golden result and keeps statistics.
module alu_response_checker #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_a,
    input  logic [31:0]       cmd_b,
    input  logic              cmd_cin,
    input  logic [2:0]        cmd_sel,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic              alu_cin,
    output logic [2:0]        alu_sel,
    input  logic [31:0]       alu_s,
    input  logic              alu_cout,
    input  logic              clear_stats,
    output logic              result_valid,
    output logic              result_pass,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic [CNT_W-1:0]  skip_count,
    output logic              first_fail_valid,
    output logic [2:0]        first_fail_sel,
    output logic [32:0]       first_fail_got,
    output logic [32:0]       first_fail_exp
);

    localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q;
    logic          accept, sample;
    logic          is_rsvd, is_match, chk_pass;
    logic [32:0]   exp_w, got_w;

    // Golden {cout,S}; SUB is A + ~B + cin so Cout=1 means no borrow.
    function automatic logic [32:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic [2:0] sel);
        logic [32:0] r;
        r = '0;
        case (sel)
            3'd0:    r = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            3'd1:    r = {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        state_d   = state_q;
        cmd_ready = (state_q == IDLE);
        accept    = 1'b0;
        sample    = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                accept  = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (tmr_q == '0) begin
                sample  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Logic ops compare S only; the ALU's Cout is don't-care for them.
    assign exp_w    = golden(alu_a, alu_b, alu_cin, alu_sel);
    assign got_w    = {alu_cout, alu_s};
    assign is_rsvd  = (alu_sel > 3'd4);
    assign is_match = (alu_sel <= 3'd1) ? (got_w == exp_w) : (alu_s == exp_w[31:0]);
    assign chk_pass = is_rsvd | is_match;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_cin <= 1'b0;
            alu_sel <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_a   <= cmd_a;
                alu_b   <= cmd_b;
                alu_cin <= cmd_cin;
                alu_sel <= cmd_sel;
                tmr_q   <= SETTLE_LD;
            end else if (state_q == WAIT && tmr_q != '0) begin
                tmr_q <= tmr_q - TW'(1);
            end
        end
    end

    // A clear on the sample edge zeroes first, then the completing result lands.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_valid     <= 1'b0;
            result_pass      <= 1'b0;
            pass_count       <= '0;
            fail_count       <= '0;
            skip_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_sel   <= '0;
            first_fail_got   <= '0;
            first_fail_exp   <= '0;
        end else begin
            result_valid <= sample;
            if (sample) result_pass <= chk_pass;
            pass_count <= sat_inc(clear_stats ? {CNT_W{1'b0}} : pass_count, sample & ~is_rsvd & is_match);
            fail_count <= sat_inc(clear_stats ? {CNT_W{1'b0}} : fail_count, sample & ~is_rsvd & ~is_match);
            skip_count <= sat_inc(clear_stats ? {CNT_W{1'b0}} : skip_count, sample & is_rsvd);
            if (sample && !chk_pass && (clear_stats || !first_fail_valid)) begin
                first_fail_valid <= 1'b1;
                first_fail_sel   <= alu_sel;
                first_fail_got   <= got_w;
                first_fail_exp   <= exp_w;
            end else if (clear_stats) begin
                first_fail_valid <= 1'b0;
                first_fail_sel   <= '0;
                first_fail_got   <= '0;
                first_fail_exp   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_response_checker.sv
// Self-checking bench for alu_response_checker: directed table, corner sequences
// and randomized operations against an arithmetic reference model.
module tb_alu_response_checker;

    localparam int SETTLE = 2;
    localparam int CNT_W  = 4;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              cmd_valid, cmd_ready, cmd_cin, alu_cin, alu_cout;
    logic [31:0]       cmd_a, cmd_b, alu_a, alu_b, alu_s;
    logic [2:0]        cmd_sel, alu_sel, first_fail_sel;
    logic              clear_stats, result_valid, result_pass, first_fail_valid;
    logic [CNT_W-1:0]  pass_count, fail_count, skip_count;
    logic [32:0]       first_fail_got, first_fail_exp, alu_drv;

    assign {alu_cout, alu_s} = alu_drv;

    alu_response_checker #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
        .alu_s(alu_s), .alu_cout(alu_cout), .clear_stats(clear_stats),
        .result_valid(result_valid), .result_pass(result_pass),
        .pass_count(pass_count), .fail_count(fail_count), .skip_count(skip_count),
        .first_fail_valid(first_fail_valid), .first_fail_sel(first_fail_sel),
        .first_fail_got(first_fail_got), .first_fail_exp(first_fail_exp)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state
    int          pm, fm, sm;
    logic        ffv;
    logic [2:0]  ffsel;
    logic [32:0] ffgot, ffexp;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [2:0]  sel;
        logic [32:0] drv;
        logic        pass;
        logic [32:0] expv;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < MAXC) ? v + 1 : v;
    endfunction

    function automatic logic [32:0] model_exp(input logic [31:0] a, input logic [31:0] b,
                                              input logic cin, input logic [2:0] sel);
        longint unsigned aa, bb, s;
        aa = a;
        bb = b;
        case (sel)
            3'd0:    s = aa + bb + cin;
            3'd1:    s = aa + (64'hFFFF_FFFF - bb) + cin;
            3'd2:    s = aa & bb;
            3'd3:    s = aa | bb;
            3'd4:    s = aa ^ bb;
            default: s = 0;
        endcase
        return s[32:0];
    endfunction

    function automatic logic model_pass(input logic [2:0] sel, input logic [32:0] drv,
                                        input logic [32:0] e);
        if (sel > 3'd4) return 1'b1;
        if (sel <= 3'd1) return drv == e;
        return drv[31:0] == e[31:0];
    endfunction

    task automatic model_reset();
        pm = 0; fm = 0; sm = 0;
        ffv = 1'b0; ffsel = '0; ffgot = '0; ffexp = '0;
    endtask

    task automatic check_stats(input string name);
        chk({name, ".pass_count"}, pass_count, pm);
        chk({name, ".fail_count"}, fail_count, fm);
        chk({name, ".skip_count"}, skip_count, sm);
        chk({name, ".ff_valid"}, first_fail_valid, ffv);
        chk({name, ".ff_sel"}, first_fail_sel, ffsel);
        chk({name, ".ff_got"}, first_fail_got, ffgot);
        chk({name, ".ff_exp"}, first_fail_exp, ffexp);
    endtask

    // Called at #1 after a rising edge; returns at #1 after the sample edge.
    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic [2:0] sel, input logic [32:0] drv,
                            input logic exp_pass, input logic [32:0] expv);
        int k;
        int lat;
        alu_drv = drv;
        cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_sel = sel; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        chk({name, ".ready"}, cmd_ready, 1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        chk({name, ".alu_a"}, alu_a, a);
        chk({name, ".alu_sel"}, alu_sel, sel);
        chk({name, ".busy"}, cmd_ready, 0);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (result_valid) begin
                lat = i;
                break;
            end
        end
        chk({name, ".latency"}, lat, SETTLE);
        if (lat == 0) return;
        chk({name, ".result_pass"}, result_pass, exp_pass);
        if (sel > 3'd4) sm = sat(sm);
        else if (exp_pass) pm = sat(pm);
        else begin
            fm = sat(fm);
            if (!ffv) begin
                ffv = 1'b1; ffsel = sel; ffgot = drv; ffexp = expv;
            end
        end
        check_stats(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rc;
        logic [2:0]  rs;
        logic [32:0] e, d;
        int          acc[$];
        int          bad;

        tbl[0] = '{a:290,  b:101,  cin:1'b1, sel:3'd0, drv:33'd392,         pass:1'b1, expv:33'd392};
        tbl[1] = '{a:101,  b:101,  cin:1'b1, sel:3'd1, drv:33'h1_0000_0000, pass:1'b1, expv:33'h1_0000_0000};
        tbl[2] = '{a:99,   b:8039, cin:1'b0, sel:3'd2, drv:33'h1_0000_0063, pass:1'b1, expv:33'd99};
        tbl[3] = '{a:1024, b:7,    cin:1'b0, sel:3'd3, drv:33'd1031,        pass:1'b1, expv:33'd1031};
        tbl[4] = '{a:255,  b:73,   cin:1'b0, sel:3'd4, drv:33'd182,         pass:1'b1, expv:33'd182};
        tbl[5] = '{a:290,  b:101,  cin:1'b1, sel:3'd0, drv:33'd393,         pass:1'b0, expv:33'd392};
        tbl[6] = '{a:5,    b:6,    cin:1'b0, sel:3'd1, drv:33'd0,           pass:1'b0, expv:33'h0_FFFF_FFFE};
        tbl[7] = '{a:1,    b:2,    cin:1'b0, sel:3'd6, drv:33'd123,         pass:1'b1, expv:33'd0};

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0;
        cmd_sel = '0; clear_stats = 1'b0; alu_drv = '0;
        model_reset();
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;

        chk("reset.cmd_ready", cmd_ready, 1);
        chk("reset.result_valid", result_valid, 0);
        chk("reset.result_pass", result_pass, 0);
        chk("reset.alu_a", alu_a, 0);
        check_stats("reset");

        for (int i = 0; i < 8; i++)
            check_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sel,
                     tbl[i].drv, tbl[i].pass, tbl[i].expv);

        // clear_stats on the sample edge of a passing op
        cmd_a = 7; cmd_b = 8; cmd_cin = 1'b0; cmd_sel = 3'd0; alu_drv = 33'd15;
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        @(posedge clock); #1;
        clear_stats = 1'b1;
        @(posedge clock); #1;
        clear_stats = 1'b0;
        chk("clr.result_valid", result_valid, 1);
        chk("clr.result_pass", result_pass, 1);
        model_reset();
        pm = 1;
        check_stats("clr");

        for (int i = 0; i < 17; i++)
            check_op("sat", i, 2 * i, 1'b0, 3'd0, model_exp(i, 2 * i, 1'b0, 3'd0), 1'b1,
                     model_exp(i, 2 * i, 1'b0, 3'd0));
        chk("sat.pass_count_max", pass_count, MAXC);

        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            rc = 1'($urandom_range(0, 1));
            rs = 3'($urandom_range(0, 7));
            e  = model_exp(ra, rb, rc, rs);
            d  = e;
            if (rs > 3'd4) d = {1'b0, $urandom};
            else if ($urandom_range(0, 3) == 0) d = e ^ (33'd1 << $urandom_range(0, 32));
            check_op("rand", ra, rb, rc, rs, d, model_pass(rs, d, e), e);
        end

        // cmd_valid held high: accepts spaced SETTLE+1 apart
        cmd_a = 1; cmd_b = 1; cmd_cin = 1'b0; cmd_sel = 3'd0; alu_drv = 33'd2;
        cmd_valid = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (cmd_ready) acc.push_back(c);
            @(posedge clock); #1;
        end
        cmd_valid = 1'b0;
        chk("stream.accepts", acc.size(), 5);
        bad = 0;
        for (int i = 1; i < acc.size(); i++)
            if (acc[i] - acc[i-1] != SETTLE + 1) bad++;
        chk("stream.spacing", bad, 0);
        for (int k = 0; k < 10 && !cmd_ready; k++) begin
            @(posedge clock); #1;
        end
        chk("stream.idle", cmd_ready, 1);

        // reset one cycle after acceptance
        cmd_a = 32'hDEAD_BEEF; cmd_b = 3; cmd_sel = 3'd2; alu_drv = 33'd0;
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        chk("rstw.alu_a_loaded", alu_a, 32'hDEAD_BEEF);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("rstw.cmd_ready", cmd_ready, 1);
        chk("rstw.alu_a", alu_a, 0);
        chk("rstw.result_valid", result_valid, 0);
        model_reset();
        check_stats("rstw");
        @(posedge clock); #1;
        reset_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            if (result_valid || !cmd_ready) bad++;
        end
        chk("rstw.no_pulse", bad, 0);
        check_stats("rstw.after");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
